cpu_io_sched: RTL and testbench
===============================

Name: cpu_io_sched

Overview:
Sequencer between the CPU execute stage and its shared side-effect resources: the 64-word data RAM and the UART.
- Takes the level-held execute requests (mem_w_req, mem_r_req, tx_req) and services one at a time.
- Drives the RAM and the UART tx handshake, and returns a single-cycle ack.
- Owns the rx-interrupt request flag (irr), the rx data latch and the tx_busy view exported to the special-register file.

Parameters:
RD_LAT, 1, RAM read latency in cycles (legal 1..3).
TX_TIMEOUT, 1023, max cycles to wait for uart_tx_busy low before abandoning a tx request (legal 1..65535).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
ex_mem_w_req  in  1  execute requests RAM write (held until ack)
ex_mem_r_req  in  1  execute requests RAM read (held until ack)
ex_mem_addr  in  6  RAM word address
ex_w_data  in  32  RAM write data
ex_tx_req  in  1  execute requests UART byte send (held until ack)
ex_tx_data  in  8  byte to send
ack  out  1  one-cycle completion pulse to execute
r_data  out  32  read data, valid when ack follows a read
ram_we  out  1  RAM write strobe
ram_re  out  1  RAM read strobe
ram_addr  out  6  RAM address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid RD_LAT cycles after ram_re cycle
uart_tx_start  out  1  one-cycle start pulse to UART tx
uart_tx_data  out  8  byte for UART tx
uart_tx_busy  in  1  UART tx shifting
uart_rx_valid  in  1  one-cycle pulse, new byte on uart_rx_data
uart_rx_data  in  8  received byte
irr_clr  in  1  CPU entered interrupt handler, clear irr
irr  out  1  interrupt request pending
rx_data  out  8  last received byte
tx_busy  out  1  uart_tx_busy OR scheduler in a tx state
err_timeout  out  1  sticky: a tx request was abandoned
err_overrun  out  1  sticky: rx byte arrived while irr set and not cleared
err_multi  out  1  sticky: more than one request sampled in IDLE

Behaviour:
- Reset: state=IDLE. ack, r_data, ram_we, ram_re, ram_addr, ram_wdata, uart_tx_start, uart_tx_data, irr, rx_data, all err_* = 0. Counters = 0.
- Reset mid-operation: in-flight op dropped, no ack issued. RAM/UART strobes low the next cycle.
- All outputs are registered except tx_busy.
- States: IDLE, RD_WAIT, TX_WAIT, DONE.
- IDLE arbitration, priority write > read > tx. Only the winner is serviced. If >1 request is sampled, set err_multi; losers are not serviced in this transaction.
- Write, sampled in cycle N:
  - Cycle N+1: ram_we=1 with ram_addr and ram_wdata, ack=1.
  - Next state DONE.
- Read, sampled in cycle N:
  - Cycle N+1: ram_re=1 with ram_addr. Enter RD_WAIT; counter runs RD_LAT cycles.
  - ram_rdata is captured in cycle N+1+RD_LAT.
  - Cycle N+2+RD_LAT: ack=1, r_data valid. Next state DONE.
  - r_data holds its value until the next read.
- Tx, sampled in cycle N: enter TX_WAIT at N+1 and clear the wait counter. In each TX_WAIT cycle:
  - If uart_tx_busy=0: next cycle uart_tx_start=1 with uart_tx_data=ex_tx_data, ack=1, then DONE.
  - Else counter+1. When counter==TX_TIMEOUT: next cycle ack=1 with no start, set err_timeout, then DONE.
- DONE: ack=0. Stay until all three ex_*_req are low, then IDLE. This prevents double service of a held request.
- ack, ram_we, ram_re and uart_tx_start are single-cycle pulses. At most one is asserted per transaction.
- tx_busy = uart_tx_busy | (state==TX_WAIT) | uart_tx_start.
- Rx side, independent of the FSM and active in every state:
  - uart_rx_valid: rx_data<=uart_rx_data, irr<=1.
  - If irr=1 and irr_clr=0 in the same cycle as uart_rx_valid: also set err_overrun.
  - irr_clr alone: irr<=0.
  - irr_clr together with uart_rx_valid: irr stays 1, new byte wins, no overrun.
- Sticky errors are cleared only by rst.

Test Plan:
- Write: ex_mem_w_req, addr=0x2A, data=0xDEADBEEF, sampled at N -> ram_we=1, ram_addr=0x2A, ram_wdata=0xDEADBEEF and ack=1 all at N+1 only. No second ack while req is held 5 more cycles.
- Read, RD_LAT=1: ex_mem_r_req, addr=0x05. RAM returns 0x12345678 one cycle after ram_re -> ram_re at N+1, ack and r_data=0x12345678 at N+3. Repeat with RD_LAT=3 -> ack at N+5.
- Tx with busy: ex_tx_req, data=0x41, uart_tx_busy high 10 cycles -> tx_busy=1 throughout. uart_tx_start and ack coincide one cycle after busy falls, uart_tx_data=0x41.
- Tx timeout, TX_TIMEOUT=8: uart_tx_busy stuck high -> ack after 8 busy cycles, no uart_tx_start, err_timeout=1 until rst.
- Rx and interrupt:
  - rx_valid 0x55 -> irr=1, rx_data=0x55.
  - Second rx_valid 0xAA without clr -> err_overrun=1, rx_data=0xAA.
  - irr_clr together with rx_valid 0x33 -> irr=1, rx_data=0x33, no new overrun.
  - irr_clr alone -> irr=0.
- Simultaneous write+read+tx requests -> only write serviced, err_multi=1. rst asserted in RD_WAIT -> no ack, all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/cpu_io_sched.sv
// cpu_io_sched: sequencer between the CPU execute stage and the shared data
// RAM (64 x 32) and UART. Services one held execute request at a time
// (write > read > tx), returns a single-cycle ack, and owns the rx interrupt
// flag, the rx data latch and the tx_busy view.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_mem_w_req/r_req       execute RAM write/read request (held until ack)
//   ex_mem_addr, ex_w_data   RAM word address and write data
//   ex_tx_req, ex_tx_data    execute UART send request and byte
//   ack, r_data              one-cycle completion pulse, read data
//   ram_we/re/addr/wdata     RAM strobes, address, write data
//   ram_rdata                RAM read data, RD_LAT cycles after ram_re
//   uart_tx_start/data       one-cycle tx start pulse and byte
//   uart_tx_busy             UART tx shifting
//   uart_rx_valid/data       received byte strobe and byte
//   irr_clr, irr, rx_data    interrupt clear, interrupt pending, last rx byte
//   tx_busy                  UART busy or scheduler owns a tx
//   err_timeout/overrun/multi sticky error flags
module cpu_io_sched #(
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned TX_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mem_w_req,
   input  logic        ex_mem_r_req,
   input  logic [5:0]  ex_mem_addr,
   input  logic [31:0] ex_w_data,
   input  logic        ex_tx_req,
   input  logic [7:0]  ex_tx_data,
   output logic        ack,
   output logic [31:0] r_data,
   output logic        ram_we,
   output logic        ram_re,
   output logic [5:0]  ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        uart_tx_start,
   output logic [7:0]  uart_tx_data,
   input  logic        uart_tx_busy,
   input  logic        uart_rx_valid,
   input  logic [7:0]  uart_rx_data,
   input  logic        irr_clr,
   output logic        irr,
   output logic [7:0]  rx_data,
   output logic        tx_busy,
   output logic        err_timeout,
   output logic        err_overrun,
   output logic        err_multi
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, TX_WAIT, DONE} state_t;

   localparam logic [15:0] RdLat = 16'(RD_LAT);
   localparam logic [15:0] TxTo  = 16'(TX_TIMEOUT);

   state_t      state_q;
   logic [15:0] cnt_q;
   logic [15:0] cnt_inc;
   logic        ack_q, ram_we_q, ram_re_q, tx_start_q;
   logic [31:0] r_data_q, ram_wdata_q;
   logic [5:0]  ram_addr_q;
   logic [7:0]  tx_data_q, rx_data_q;
   logic        irr_q, err_timeout_q, err_overrun_q, err_multi_q;
   logic        multi_req, any_req;

   assign cnt_inc   = cnt_q + 16'd1;
   assign multi_req = (ex_mem_w_req & ex_mem_r_req) | (ex_mem_w_req & ex_tx_req) |
                      (ex_mem_r_req & ex_tx_req);
   assign any_req   = ex_mem_w_req | ex_mem_r_req | ex_tx_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         ack_q         <= 1'b0;
         r_data_q      <= '0;
         ram_we_q      <= 1'b0;
         ram_re_q      <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         irr_q         <= 1'b0;
         rx_data_q     <= '0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
         err_multi_q   <= 1'b0;
      end else begin
         // Pulses default low; each state raises at most one of them.
         ack_q      <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_re_q   <= 1'b0;
         tx_start_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (multi_req) err_multi_q <= 1'b1;
               if (ex_mem_w_req) begin
                  ram_we_q    <= 1'b1;
                  ram_addr_q  <= ex_mem_addr;
                  ram_wdata_q <= ex_w_data;
                  ack_q       <= 1'b1;
                  state_q     <= DONE;
               end else if (ex_mem_r_req) begin
                  ram_re_q   <= 1'b1;
                  ram_addr_q <= ex_mem_addr;
                  cnt_q      <= '0;
                  state_q    <= RD_WAIT;
               end else if (ex_tx_req) begin
                  cnt_q   <= '0;
                  state_q <= TX_WAIT;
               end
            end
            RD_WAIT: begin
               // First RD_WAIT cycle is the ram_re cycle, so data lands when cnt == RD_LAT.
               if (cnt_q == RdLat) begin
                  r_data_q <= ram_rdata;
                  ack_q    <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            TX_WAIT: begin
               if (!uart_tx_busy) begin
                  tx_start_q <= 1'b1;
                  tx_data_q  <= ex_tx_data;
                  ack_q      <= 1'b1;
                  state_q    <= DONE;
               end else if (cnt_inc == TxTo) begin
                  ack_q         <= 1'b1;
                  err_timeout_q <= 1'b1;
                  state_q       <= DONE;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            DONE: begin
               // Wait for execute to drop its request so it is not serviced twice.
               if (!any_req) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         // Rx side runs in every state; a byte arriving with irr_clr keeps irr set.
         if (uart_rx_valid) begin
            rx_data_q <= uart_rx_data;
            irr_q     <= 1'b1;
            if (irr_q && !irr_clr) err_overrun_q <= 1'b1;
         end else if (irr_clr) begin
            irr_q <= 1'b0;
         end
      end
   end

   assign ack           = ack_q;
   assign r_data        = r_data_q;
   assign ram_we        = ram_we_q;
   assign ram_re        = ram_re_q;
   assign ram_addr      = ram_addr_q;
   assign ram_wdata     = ram_wdata_q;
   assign uart_tx_start = tx_start_q;
   assign uart_tx_data  = tx_data_q;
   assign irr           = irr_q;
   assign rx_data       = rx_data_q;
   assign err_timeout   = err_timeout_q;
   assign err_overrun   = err_overrun_q;
   assign err_multi     = err_multi_q;
   assign tx_busy       = uart_tx_busy | (state_q == TX_WAIT) | tx_start_q;

endmodule

// File: tb/tb_cpu_io_sched.sv
// Bench for cpu_io_sched: two instances (RD_LAT=1/TX_TIMEOUT=8 and
// RD_LAT=3/TX_TIMEOUT=20), each with a behavioural RAM, driven by directed
// and random transactions while a concurrent process exercises the rx side.
module tb_cpu_io_sched;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        w_req [2], r_req [2], tx_req [2];
   logic [5:0]  addr  [2];
   logic [31:0] wdata [2];
   logic [7:0]  txd   [2];
   logic        ack   [2];
   logic [31:0] r_data[2];
   logic        ram_we[2], ram_re[2];
   logic [5:0]  ram_addr[2];
   logic [31:0] ram_wdata[2];
   logic        start [2];
   logic [7:0]  tx_data_o[2];
   logic        busy  [2];
   logic        rxv   [2], clr[2];
   logic [7:0]  rxd_in[2];
   logic        irr   [2];
   logic [7:0]  rx_data[2];
   logic        tx_busy[2], e_to[2], e_ov[2], e_mu[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 1 : 3;
      logic [31:0] mem  [64];
      logic        hre  [4];
      logic [5:0]  haddr[4];
      logic [31:0] rdata;

      cpu_io_sched #(.RD_LAT(LAT), .TX_TIMEOUT((g == 0) ? 8 : 20)) u_dut (
         .clk(clk), .rst(rst),
         .ex_mem_w_req(w_req[g]), .ex_mem_r_req(r_req[g]), .ex_mem_addr(addr[g]),
         .ex_w_data(wdata[g]), .ex_tx_req(tx_req[g]), .ex_tx_data(txd[g]),
         .ack(ack[g]), .r_data(r_data[g]),
         .ram_we(ram_we[g]), .ram_re(ram_re[g]), .ram_addr(ram_addr[g]),
         .ram_wdata(ram_wdata[g]), .ram_rdata(rdata),
         .uart_tx_start(start[g]), .uart_tx_data(tx_data_o[g]), .uart_tx_busy(busy[g]),
         .uart_rx_valid(rxv[g]), .uart_rx_data(rxd_in[g]), .irr_clr(clr[g]),
         .irr(irr[g]), .rx_data(rx_data[g]), .tx_busy(tx_busy[g]),
         .err_timeout(e_to[g]), .err_overrun(e_ov[g]), .err_multi(e_mu[g])
      );

      initial begin
         for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
         for (int k = 0; k < 4; k++) begin hre[k] = 1'b0; haddr[k] = '0; end
         rdata = '0;
      end

      // RAM: data for a ram_re in cycle c is presented only during cycle c+LAT.
      always @(negedge clk) begin
         for (int k = 3; k > 0; k--) begin hre[k] = hre[k-1]; haddr[k] = haddr[k-1]; end
         hre[0]   = ram_re[g];
         haddr[0] = ram_addr[g];
         if (ram_we[g]) mem[ram_addr[g]] = ram_wdata[g];
         rdata = hre[LAT] ? mem[haddr[LAT]] : $urandom;
      end
   end

   int          n_total, n_bad;
   logic [31:0] shadow[2][64];
   logic [31:0] exp_rdata[2];
   logic [7:0]  exp_txd[2];
   logic        exp_to[2], exp_mu[2];
   logic        m_irr[2], m_ovr[2];
   logic [7:0]  m_rxd[2];
   logic        pv[2], pc[2];
   logic [7:0]  pd[2];
   bit          done;

   function automatic int lat_of(int d); return (d == 0) ? 1 : 3; endfunction
   function automatic int to_of(int d);  return (d == 0) ? 8 : 20; endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic no_pulse(int d);
      check($sformatf("ack%0d", d), 32'(ack[d]), 0);
      check($sformatf("ram_we%0d", d), 32'(ram_we[d]), 0);
      check($sformatf("ram_re%0d", d), 32'(ram_re[d]), 0);
      check($sformatf("tx_start%0d", d), 32'(start[d]), 0);
   endtask

   task automatic reset_model();
      for (int d = 0; d < 2; d++) begin
         exp_rdata[d] = '0; exp_txd[d] = '0; exp_to[d] = 1'b0; exp_mu[d] = 1'b0;
         m_irr[d] = 1'b0; m_ovr[d] = 1'b0; m_rxd[d] = '0;
      end
   endtask

   task automatic chk_reset(int d);
      no_pulse(d);
      check($sformatf("rst_r_data%0d", d), r_data[d], 0);
      check($sformatf("rst_ram_addr%0d", d), 32'(ram_addr[d]), 0);
      check($sformatf("rst_ram_wdata%0d", d), ram_wdata[d], 0);
      check($sformatf("rst_tx_data%0d", d), 32'(tx_data_o[d]), 0);
      check($sformatf("rst_irr%0d", d), 32'(irr[d]), 0);
      check($sformatf("rst_rx_data%0d", d), 32'(rx_data[d]), 0);
      check($sformatf("rst_tx_busy%0d", d), 32'(tx_busy[d]), 0);
      check($sformatf("rst_errs%0d", d), {29'd0, e_to[d], e_ov[d], e_mu[d]}, 0);
   endtask

   task automatic chk_errs(int d);
      check($sformatf("err_timeout%0d", d), 32'(e_to[d]), 32'(exp_to[d]));
      check($sformatf("err_multi%0d", d), 32'(e_mu[d]), 32'(exp_mu[d]));
      check($sformatf("err_overrun%0d", d), 32'(e_ov[d]), 32'(m_ovr[d]));
   endtask

   // Hold the request `hold` cycles past ack (no re-service), then drop it.
   task automatic finish_txn(int d, int hold);
      repeat (hold) begin
         step();
         no_pulse(d);
         check($sformatf("r_data_hold%0d", d), r_data[d], exp_rdata[d]);
      end
      w_req[d] = 1'b0; r_req[d] = 1'b0; tx_req[d] = 1'b0;
      step();
      no_pulse(d);
   endtask

   task automatic do_write(int d, logic [5:0] a, logic [31:0] dat, int hold);
      addr[d] = a; wdata[d] = dat; w_req[d] = 1'b1;
      step();
      check($sformatf("wr_ack%0d", d), 32'(ack[d]), 1);
      check($sformatf("wr_we%0d", d), 32'(ram_we[d]), 1);
      check($sformatf("wr_re%0d", d), 32'(ram_re[d]), 0);
      check($sformatf("wr_addr%0d", d), 32'(ram_addr[d]), 32'(a));
      check($sformatf("wr_wdata%0d", d), ram_wdata[d], dat);
      shadow[d][a] = dat;
      finish_txn(d, hold);
   endtask

   task automatic do_read(int d, logic [5:0] a, int hold);
      addr[d] = a; r_req[d] = 1'b1;
      step();
      check($sformatf("rd_re%0d", d), 32'(ram_re[d]), 1);
      check($sformatf("rd_addr%0d", d), 32'(ram_addr[d]), 32'(a));
      check($sformatf("rd_early_ack%0d", d), 32'(ack[d]), 0);
      for (int k = 0; k < lat_of(d); k++) begin
         step();
         no_pulse(d);
      end
      step();
      check($sformatf("rd_ack%0d", d), 32'(ack[d]), 1);
      check($sformatf("rd_data%0d", d), r_data[d], shadow[d][a]);
      exp_rdata[d] = shadow[d][a];
      finish_txn(d, hold);
   endtask

   // b = number of TX_WAIT cycles that see uart_tx_busy high.
   task automatic do_tx(int d, logic [7:0] dat, int b, int hold);
      bit timed;
      timed = 1'b0;
      txd[d] = dat; tx_req[d] = 1'b1; busy[d] = (b > 0);
      step();
      for (int k = 0; k <= to_of(d); k++) begin
         no_pulse(d);
         busy[d] = (k < b);
         #1;
         check($sformatf("tx_wait_busy%0d", d), 32'(tx_busy[d]), 1);
         if (k >= b) break;
         if (k + 1 == to_of(d)) begin timed = 1'b1; break; end
         step();
      end
      step();
      check($sformatf("tx_ack%0d", d), 32'(ack[d]), 1);
      check($sformatf("tx_start%0d", d), 32'(start[d]), timed ? 0 : 1);
      if (!timed) begin
         exp_txd[d] = dat;
         check($sformatf("tx_start_busy%0d", d), 32'(tx_busy[d]), 1);
      end else begin
         exp_to[d] = 1'b1;
      end
      check($sformatf("tx_data%0d", d), 32'(tx_data_o[d]), 32'(exp_txd[d]));
      check($sformatf("tx_err_timeout%0d", d), 32'(e_to[d]), 32'(exp_to[d]));
      busy[d] = 1'b0;
      finish_txn(d, hold);
   endtask

   // Apply pv/pc/pd to both instances for one cycle and check the rx view.
   task automatic rx_tick();
      for (int d = 0; d < 2; d++) begin
         rxv[d] = pv[d]; clr[d] = pc[d]; rxd_in[d] = pd[d];
         if (pv[d]) begin
            if (m_irr[d] && !pc[d]) m_ovr[d] = 1'b1;
            m_irr[d] = 1'b1;
            m_rxd[d] = pd[d];
         end else if (pc[d]) begin
            m_irr[d] = 1'b0;
         end
      end
      step();
      for (int d = 0; d < 2; d++) begin
         rxv[d] = 1'b0; clr[d] = 1'b0; pv[d] = 1'b0; pc[d] = 1'b0; pd[d] = '0;
         check($sformatf("irr%0d", d), 32'(irr[d]), 32'(m_irr[d]));
         check($sformatf("rx_data%0d", d), 32'(rx_data[d]), 32'(m_rxd[d]));
         check($sformatf("overrun%0d", d), 32'(e_ov[d]), 32'(m_ovr[d]));
      end
   endtask

   task automatic rx_set(int d, logic v, logic c, logic [7:0] dat);
      pv[d] = v; pc[d] = c; pd[d] = dat;
   endtask

   initial begin
      n_total = 0; n_bad = 0; done = 1'b0;
      for (int d = 0; d < 2; d++) begin
         w_req[d] = 0; r_req[d] = 0; tx_req[d] = 0; addr[d] = '0; wdata[d] = '0;
         txd[d] = '0; busy[d] = 0; rxv[d] = 0; clr[d] = 0; rxd_in[d] = '0;
         pv[d] = 0; pc[d] = 0; pd[d] = '0;
         for (int i = 0; i < 64; i++) shadow[d][i] = 32'hA500_0000 | 32'(i);
      end
      reset_model();

      rst = 1'b1;
      repeat (3) step();
      for (int d = 0; d < 2; d++) chk_reset(d);
      rst = 1'b0;

      // Directed transactions
      do_write(0, 6'h2A, 32'hDEADBEEF, 5);
      do_write(0, 6'h05, 32'h12345678, 0);
      do_write(1, 6'h05, 32'h12345678, 0);
      do_read(0, 6'h05, 1);
      do_read(1, 6'h05, 2);
      do_tx(1, 8'h41, 10, 1);
      do_tx(0, 8'h5A, 1000, 2);
      chk_errs(0);
      chk_errs(1);

      // Directed rx / interrupt
      rx_set(0, 1, 0, 8'h55); rx_tick();
      rx_set(0, 1, 0, 8'hAA); rx_tick();
      rx_set(0, 1, 1, 8'h33); rx_tick();
      rx_set(0, 0, 1, 8'h00); rx_tick();
      rx_set(1, 1, 0, 8'h10); rx_tick();
      rx_set(1, 1, 1, 8'h33); rx_tick();
      rx_set(1, 0, 1, 8'h00); rx_tick();
      rx_tick();

      // Simultaneous requests: only the write is serviced
      addr[0] = 6'h11; wdata[0] = 32'hCAFEF00D; txd[0] = 8'h77;
      w_req[0] = 1; r_req[0] = 1; tx_req[0] = 1;
      step();
      check("multi_ack", 32'(ack[0]), 1);
      check("multi_we", 32'(ram_we[0]), 1);
      check("multi_re", 32'(ram_re[0]), 0);
      check("multi_start", 32'(start[0]), 0);
      check("multi_wdata", ram_wdata[0], 32'hCAFEF00D);
      shadow[0][6'h11] = 32'hCAFEF00D;
      exp_mu[0] = 1'b1;
      finish_txn(0, 2);
      chk_errs(0);
      chk_errs(1);

      // Random transactions with concurrent random rx traffic
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               for (int d = 0; d < 2; d++) begin
                  case ($urandom_range(0, 2))
                     0: do_write(d, 6'($urandom_range(0, 63)), $urandom, $urandom_range(0, 3));
                     1: do_read(d, 6'($urandom_range(0, 63)), $urandom_range(0, 3));
                     default: do_tx(d, 8'($urandom), $urandom_range(0, to_of(d) + 3),
                                    $urandom_range(0, 3));
                  endcase
               end
            end
            done = 1'b1;
         end
         begin
            for (int n = 0; n < 20000 && !done; n++) begin
               for (int d = 0; d < 2; d++)
                  rx_set(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 8'($urandom));
               rx_tick();
            end
         end
      join
      for (int d = 0; d < 2; d++) chk_errs(d);

      // Reset while instance 1 sits in RD_WAIT
      addr[1] = 6'h07; r_req[1] = 1'b1;
      step();
      check("rstop_re", 32'(ram_re[1]), 1);
      step();
      no_pulse(1);
      rst = 1'b1; r_req[1] = 1'b0;
      step();
      for (int d = 0; d < 2; d++) chk_reset(d);
      rst = 1'b0;
      reset_model();
      repeat (5) begin
         step();
         no_pulse(1);
      end
      do_read(1, 6'h07, 0);
      do_write(1, 6'h3F, 32'h0BADF00D, 1);
      for (int d = 0; d < 2; d++) chk_errs(d);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
